// File: rtl/cross_switch_n.sv
`default_nettype none
// ============================================================================
// Module   : cross_switch_n
// Purpose  : N-lane registered crossbar. Each output lane picks its source
//            lane through a runtime-loadable select register. The block has
//            one valid/ready output stage and a delivered-beat counter.
// Revision : 1.0 - initial release
// ============================================================================
module cross_switch_n #(
  parameter  int WIDTH = 16,
  parameter  int NCH   = 4,
  localparam int SELW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_we,
  input  logic [NCH*SELW-1:0]   cfg_sel,
  output logic                  cfg_err,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NCH*WIDTH-1:0]  din,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NCH*WIDTH-1:0]  dout,
  input  logic                  cnt_clr,
  output logic [15:0]           beat_cnt
);

  // One extra bit so the lane count itself is representable for the range check.
  localparam logic [SELW:0] c_nch = (SELW + 1)'(NCH);

  logic [SELW-1:0]      act_sel_q [NCH];
  logic [SELW-1:0]      act_sel_d [NCH];
  logic                 cfg_err_q, cfg_err_d;
  logic                 out_valid_q, out_valid_d;
  logic [NCH*WIDTH-1:0] dout_q, dout_d;
  logic [15:0]          beat_cnt_q, beat_cnt_d;

  logic [NCH-1:0]       w_sel_bad;
  logic [NCH*WIDTH-1:0] w_routed;
  logic                 w_accept;
  logic                 w_take;

  assign in_ready  = !out_valid_q || out_ready;
  assign w_accept  = in_valid && in_ready;
  assign w_take    = out_valid_q && out_ready;

  generate
    for (genvar j = 0; j < NCH; j++) begin : g_lane
      logic [WIDTH-1:0] lane_mux;

      assign w_sel_bad[j] = {1'b0, cfg_sel[j*SELW +: SELW]} >= c_nch;

      // Indices with no matching lane fall through to zero.
      always_comb begin
        lane_mux = '0;
        for (int i = 0; i < NCH; i++) begin
          if (act_sel_q[j] == SELW'(i)) begin
            lane_mux = din[i*WIDTH +: WIDTH];
          end
        end
      end

      assign w_routed[j*WIDTH +: WIDTH] = lane_mux;
    end
  endgenerate

  always_comb begin
    for (int j = 0; j < NCH; j++) begin
      act_sel_d[j] = cfg_we ? cfg_sel[j*SELW +: SELW] : act_sel_q[j];
    end
  end

  always_comb begin
    cfg_err_d = cfg_err_q || (cfg_we && (|w_sel_bad));
  end

  // Routing uses the pre-edge selects, so a beat accepted alongside a config
  // write still follows the old routing.
  always_comb begin
    out_valid_d = out_valid_q;
    dout_d      = dout_q;
    if (w_accept) begin
      out_valid_d = 1'b1;
      dout_d      = w_routed;
    end else if (w_take) begin
      out_valid_d = 1'b0;
    end
  end

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (cnt_clr) begin
      beat_cnt_d = '0;
    end else if (w_take) begin
      beat_cnt_d = beat_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < NCH; j++) begin
        act_sel_q[j] <= SELW'(j);
      end
      cfg_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      beat_cnt_q  <= '0;
    end else begin
      for (int j = 0; j < NCH; j++) begin
        act_sel_q[j] <= act_sel_d[j];
      end
      cfg_err_q   <= cfg_err_d;
      out_valid_q <= out_valid_d;
      dout_q      <= dout_d;
      beat_cnt_q  <= beat_cnt_d;
    end
  end

  assign cfg_err   = cfg_err_q;
  assign out_valid = out_valid_q;
  assign dout      = dout_q;
  assign beat_cnt  = beat_cnt_q;

endmodule
`default_nettype wire

// File: doc/cross_switch_n.md
# cross_switch_n

Parametrised N-channel registered crossbar; successor to the 2-channel cross demux. Each output lane selects any input lane through a per-lane select register, so one block covers straight, swap, arbitrary permutation and broadcast routing. Sits between the on-chip buffers and the PE array. Has one valid/ready pipeline stage, a runtime-loadable routing configuration and a beat counter for the control FSM.

## Interface
- WIDTH, 16, data width per lane
- NCH, 4, number of lanes (2..16); SELW = max(1, clog2(NCH)) is a localparam
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- cfg_we  in  1  load routing configuration this cycle
- cfg_sel  in  NCH*SELW  per-output-lane source index; lane j at bits [j*SELW +: SELW]
- cfg_err  out  1  sticky: a loaded index was >= NCH
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- din  in  NCH*WIDTH  input lanes; lane i at bits [i*WIDTH +: WIDTH]
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts the beat
- dout  out  NCH*WIDTH  routed output lanes, same packing as din
- cnt_clr  in  1  synchronous clear of beat_cnt
- beat_cnt  out  16  number of beats delivered downstream (out_valid && out_ready)

## Operation
- Active select register act_sel[j]: on reset, act_sel[j] = j (identity routing).
- Config load:
  - cfg_we=1 writes cfg_sel into act_sel at the clock edge.
  - A beat accepted in the same cycle routes with the pre-edge act_sel.
  - The new routing applies from the next accepted beat.
- Routing at accept (in_valid && in_ready):
  - dout lane j <= din lane act_sel[j] when act_sel[j] < NCH.
  - Otherwise dout lane j <= 0.
- Duplicate indices are legal (broadcast). No uniqueness check.
- cfg_err: set when cfg_we=1 and any cfg_sel lane >= NCH. Cleared only by reset. Cannot set when NCH is a power of two.
- Output stage:
  - in_ready = !out_valid || out_ready (combinational, no skid).
  - Accept: out_valid <= 1 and dout loads.
  - out_valid && out_ready without a new accept: out_valid <= 0.
  - dout holds its last value when out_valid=0.
- beat_cnt:
  - Increments on each out_valid && out_ready.
  - Wraps from 0xFFFF to 0x0000.
  - cnt_clr has priority over increment: the result is 0 even if a beat completes that cycle.

## Timing
- Latency 1 cycle: a beat accepted at edge k is visible on dout/out_valid after edge k.
- Throughput 1 beat/cycle while out_ready=1.
- Stall:
  - While out_valid=1 and out_ready=0, dout and out_valid stay stable and in_ready=0.
  - in_valid/din are ignored while in_ready=0.
- Simultaneous downstream take and upstream accept: the new beat replaces the old one and out_valid stays 1.
- Reset values: out_valid=0, dout=0, cfg_err=0, beat_cnt=0, act_sel identity; in_ready=1 after reset.
- Reset mid-stall: the held beat is discarded, with no partial output.
- cfg_we during a stall: act_sel updates; the held dout is unchanged.

## Test plan
- Reset, NCH=4, WIDTH=16:
  - din={0x0004,0x0003,0x0002,0x0001}, in_valid=1, out_ready=1.
  - Required: dout equals din one cycle later, out_valid=1, beat_cnt=1 after the transfer.
- Swap and permute:
  - Load cfg_sel lanes {1,0,3,2} with the same din.
  - Required: dout={0x0003,0x0004,0x0001,0x0002}.
  - A beat accepted in the cfg_we cycle still routes by identity.
- Broadcast:
  - cfg_sel all 2, din lane2=0xABCD.
  - Required: all four dout lanes = 0xABCD.
- Backpressure:
  - Stream beats 1..8 with out_ready toggling 1,0,0,1.
  - Required: no beat lost or duplicated, dout stable while stalled, in_ready=0 during stall, beat_cnt=8.
- NCH=3 (SELW=2):
  - Load lane sel {3,0,1}.
  - Required: cfg_err=1 (sticky); output lane0=0; lanes 1,2 = din lanes 0,1.
- Counter:
  - Preload by 65535 transfers, then one more.
  - Required: beat_cnt wraps to 0.
  - cnt_clr asserted together with a transfer gives 0.
  - rst_n pulsed mid-stall clears out_valid asynchronously.
